// File: rtl/serial_full_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: the 2-bit FSM state encoding.
package serial_full_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : serial_full_subtractor_pkg

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: diff = x - y - bi, borrow out when the result goes negative.
module full_subtractor_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic bi_i,
    output logic diff_o,
    output logic bo_o
);

    // Difference bit and borrow out of a single bit position.
    always_comb begin
        diff_o = x_i ^ y_i ^ bi_i;
        bo_o   = (~x_i & y_i) | (~(x_i ^ y_i) & bi_i);
    end

endmodule : full_subtractor_cell

// File: rtl/serial_full_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, LSB first, one bit per clock
// through a single full_subtractor_cell and a registered borrow.
// Optional build macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_full_subtractor
    import serial_full_subtractor_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q;
    logic [N-1:0]  sa_q;
    logic [N-1:0]  sb_q;
    logic [N-1:0]  d_sh_q;
    logic          br_q;
    logic [CW-1:0] count_q;
    logic          diff_s;
    logic          bo_s;
    logic [N-1:0]  d_sh_d;
`ifdef SERIAL_SUB_OVF_EN
    logic          a_msb_q;
    logic          b_msb_q;
`endif

    full_subtractor_cell u_cell (
        .x_i    (sa_q[0]),
        .y_i    (sb_q[0]),
        .bi_i   (br_q),
        .diff_o (diff_s),
        .bo_o   (bo_s)
    );

    // Next value of the internal difference shifter: new bit enters at the MSB.
    always_comb begin
        d_sh_d        = d_sh_q >> 1'b1;
        d_sh_d[N-1]   = diff_s;
    end

    // Control FSM with operand/borrow shifters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= {N{1'b0}};
            sb_q    <= {N{1'b0}};
            d_sh_q  <= {N{1'b0}};
            br_q    <= 1'b0;
            count_q <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= {N{1'b0}};
            bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= bin;
                        count_q <= {CW{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a[N-1];
                        b_msb_q <= b[N-1];
`endif
                        state_q <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here: the running operation owns the datapath.
                    sa_q    <= sa_q >> 1'b1;
                    sb_q    <= sb_q >> 1'b1;
                    br_q    <= bo_s;
                    d_sh_q  <= d_sh_d;
                    count_q <= count_q + CNT_ONE;
                    if (count_q == CNT_LAST) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                DONE: begin
                    // Publish the finished result; outputs stay put through the next SHIFT.
                    done <= 1'b1;
                    d    <= d_sh_q;
                    bout <= br_q;
`ifdef SERIAL_SUB_OVF_EN
                    ovf  <= (a_msb_q ^ b_msb_q) & (d_sh_q[N-1] ^ a_msb_q);
`endif
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= bin;
                        count_q <= {CW{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a[N-1];
                        b_msb_q <= b[N-1];
`endif
                        state_q <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_full_subtractor

// File: tb/tb_serial_full_subtractor.sv
// Directed self-checking bench for serial_full_subtractor (N=4).
// Build with SERIAL_SUB_OVF_EN defined to also check the ovf output.
`timescale 1ns/1ps
module tb_serial_full_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    serial_full_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation started in "cycle 0"; done expected in cycle 6.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                          input logic [3:0] exp_d, input logic exp_bo, input string tag);
        int cyc;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        start = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;
        while (done !== 1'b1 && cyc < 20) begin
            chk({tag, "_busy"}, {31'd0, busy}, (cyc <= N) ? 32'd1 : 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 32'd6);
        chk({tag, "_d"}, {28'd0, d}, {28'd0, exp_d});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bo});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, {28'd0, d}, {28'd0, exp_d});
    endtask

    initial begin
        int cyc;
        int guard;
        int seen;
        int issued;
        logic [5:0] exp_q[$];
        logic [5:0] e;
        logic [8:0] jv;
        logic [4:0] full;
        logic [3:0] p_a[3];
        logic [3:0] p_b[3];
        logic       p_bin[3];
        logic [3:0] p_d[3];
        logic       p_bo[3];

        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", {28'd0, d}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed operations with hand-computed results.
        run_op(4'd9, 4'd5, 1'b0, 4'd4, 1'b0, "9m5");
        run_op(4'd5, 4'd9, 1'b0, 4'b1100, 1'b1, "5m9");
        run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "0m0b");
        run_op(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, "fmf");
        run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, "8m1");
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_8m1", {31'd0, ovf}, 32'd1);
`endif
        run_op(4'd3, 4'd1, 1'b0, 4'd2, 1'b0, "3m1");
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_3m1", {31'd0, ovf}, 32'd0);
`endif

        // start pulses at cycles 2 and 3 of a running operation are ignored.
        a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd14; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_lat", cyc, 32'd6);
        chk("ign_d", {28'd0, d}, 32'd4);
        chk("ign_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);

        // start held high: a result every 5 cycles.
        p_a[0] = 4'd9; p_b[0] = 4'd5; p_bin[0] = 1'b0; p_d[0] = 4'd4;  p_bo[0] = 1'b0;
        p_a[1] = 4'd5; p_b[1] = 4'd9; p_bin[1] = 1'b0; p_d[1] = 4'd12; p_bo[1] = 1'b1;
        p_a[2] = 4'd0; p_b[2] = 4'd0; p_bin[2] = 1'b1; p_d[2] = 4'd15; p_bo[2] = 1'b1;
        a = p_a[0]; b = p_b[0]; bin = p_bin[0]; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        a = p_a[1]; b = p_b[1]; bin = p_bin[1];
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            while (done !== 1'b1 && guard < 20) begin
                @(negedge clk);
                cyc++;
                guard++;
            end
            chk("b2b_cyc", cyc, 32'(6 + 5 * i));
            chk("b2b_d", {28'd0, d}, {28'd0, p_d[i]});
            chk("b2b_bout", {31'd0, bout}, {31'd0, p_bo[i]});
            if (i == 0) begin
                a = p_a[2]; b = p_b[2]; bin = p_bin[2];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end

        // Reset in cycle 2 of an operation aborts it with no done pulse.
        a = 4'd3; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_d", {28'd0, d}, 32'd0);
        chk("mrst_bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("mrst_nodone", seen, 32'd0);

        // Exhaustive back-to-back sweep against the arithmetic reference.
        issued = 0;
        jv = 9'(issued);
        a = jv[8:5]; b = jv[4:1]; bin = jv[0]; start = 1'b1;
        full = {1'b0, jv[8:5]} - {1'b0, jv[4:1]} - {4'd0, jv[0]};
        exp_q.push_back({(jv[8] ^ jv[4]) & (full[3] ^ jv[8]), full});
        issued++;
        @(negedge clk);
        jv = 9'(issued);
        a = jv[8:5]; b = jv[4:1]; bin = jv[0];
        full = {1'b0, jv[8:5]} - {1'b0, jv[4:1]} - {4'd0, jv[0]};
        exp_q.push_back({(jv[8] ^ jv[4]) & (full[3] ^ jv[8]), full});
        issued++;
        while (exp_q.size() > 0) begin
            guard = 0;
            while (done !== 1'b1 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            if (done !== 1'b1) begin
                chk("sw_timeout", {31'd0, done}, 32'd1);
                break;
            end
            e = exp_q.pop_front();
            chk("sw_dbout", {27'd0, bout, d}, {27'd0, e[4:0]});
`ifdef SERIAL_SUB_OVF_EN
            chk("sw_ovf", {31'd0, ovf}, {31'd0, e[5]});
`endif
            if (issued < 512) begin
                jv = 9'(issued);
                a = jv[8:5]; b = jv[4:1]; bin = jv[0];
                full = {1'b0, jv[8:5]} - {1'b0, jv[4:1]} - {4'd0, jv[0]};
                exp_q.push_back({(jv[8] ^ jv[4]) & (full[3] ^ jv[8]), full});
                issued++;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_serial_full_subtractor
